// File: rtl/reg_window_decoder_pkg.sv
// Shared constants for the register-window decoder: region tags and FSM encodings.
package reg_dec_pkg;

  localparam logic [1:0] RD_TAG = 2'b11;
  localparam logic [1:0] RP_TAG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_window_decoder_if.sv
// Spill/fill handshake between the window decoder (master) and the load/store unit (slave).
interface reg_window_decoder_if #(
  parameter int WPW = 2
);

  logic           spill_req_o;
  logic [WPW-1:0] spill_win_o;
  logic           spill_ack_i;
  logic           fill_req_o;
  logic [WPW-1:0] fill_win_o;
  logic           fill_ack_i;

  modport master (
    output spill_req_o, spill_win_o, fill_req_o, fill_win_o,
    input  spill_ack_i, fill_ack_i
  );

  modport slave (
    input  spill_req_o, spill_win_o, fill_req_o, fill_win_o,
    output spill_ack_i, fill_ack_i
  );

endinterface

// File: rtl/reg_field_expand.sv
// Builds one physical register address as {window, region tag, field}.
module reg_field_expand #(
  parameter int WPW  = 2,
  parameter int TAGW = 2,
  parameter int FW   = 2
) (
  input  logic [WPW-1:0]          win,
  input  logic [TAGW-1:0]         tag,
  input  logic [FW-1:0]           field,
  output logic [WPW+TAGW+FW-1:0]  addr
);

  assign addr = {win, tag, field};

endmodule

// File: rtl/reg_window_decoder.sv
// Expands packed Rd/Rp fields into windowed physical addresses and tracks the
// current window pointer across call/return, spilling/filling windows via the LSU.
module reg_window_decoder
  import reg_dec_pkg::*;
#(
  parameter int FW   = 2,
  parameter int NWIN = 4,
  parameter int TAGW = 2,
  parameter int DW   = 8,
  localparam int WPW = $clog2(NWIN),
  localparam int PAW = WPW + TAGW + FW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid_i,
  input  logic [2*FW-1:0]      r_i,
  output logic                 dec_valid_o,
  output logic [PAW-1:0]       rd_addr_o,
  output logic [PAW-1:0]       rp_addr_o,
  input  logic                 call_i,
  input  logic                 ret_i,
  output logic                 busy_o,
  reg_window_decoder_if.master lsu,
  output logic [DW-1:0]        depth_o,
  output logic                 underflow_o,
  output logic                 overflow_o
);

  localparam int RW = WPW + 1;
  localparam logic [RW-1:0]  RES_ONE   = RW'(1);
  localparam logic [RW-1:0]  RES_FULL  = RW'(NWIN);
  localparam logic [DW-1:0]  DEPTH_MAX = '1;
  localparam logic [WPW-1:0] WIN_ONE   = WPW'(1);

  state_t         state_reg, state_next;
  logic [WPW-1:0] cwp_reg, cwp_next;
  logic [RW-1:0]  resident_reg, resident_next;
  logic [DW-1:0]  depth_reg, depth_next;
  logic           ovf_reg, ovf_next;
  logic           unf_reg, unf_next;
  logic           dec_valid_reg;
  logic [PAW-1:0] rd_addr_reg, rp_addr_reg;

  // Index 0 expands Rd into the local region, index 1 expands Rp into the caller's window.
  logic [WPW-1:0]  win_sel   [2];
  logic [TAGW-1:0] tag_sel   [2];
  logic [FW-1:0]   field_sel [2];
  logic [PAW-1:0]  addr_sel  [2];

  assign win_sel[0]   = cwp_reg;
  assign win_sel[1]   = (depth_reg != '0) ? cwp_reg - WIN_ONE : cwp_reg;
  assign tag_sel[0]   = TAGW'(RD_TAG);
  assign tag_sel[1]   = TAGW'(RP_TAG);
  assign field_sel[0] = r_i[2*FW-1:FW];
  assign field_sel[1] = r_i[FW-1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_expand
      reg_field_expand #(
        .WPW  (WPW),
        .TAGW (TAGW),
        .FW   (FW)
      ) u_expand (
        .win   (win_sel[gi]),
        .tag   (tag_sel[gi]),
        .field (field_sel[gi]),
        .addr  (addr_sel[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cwp_reg       <= '0;
      resident_reg  <= RES_ONE;
      depth_reg     <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      dec_valid_reg <= 1'b0;
      rd_addr_reg   <= '0;
      rp_addr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cwp_reg       <= cwp_next;
      resident_reg  <= resident_next;
      depth_reg     <= depth_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
      dec_valid_reg <= dec_valid_i;
      rd_addr_reg   <= addr_sel[0];
      rp_addr_reg   <= addr_sel[1];
    end
  end

  always_comb begin
    state_next    = state_reg;
    cwp_next      = cwp_reg;
    resident_next = resident_reg;
    depth_next    = depth_reg;
    ovf_next      = ovf_reg;
    unf_next      = unf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (call_i && !ret_i) begin
          if (depth_reg == DEPTH_MAX) begin
            ovf_next = 1'b1;
          end else if (resident_reg < RES_FULL) begin
            cwp_next      = cwp_reg + WIN_ONE;
            resident_next = resident_reg + RES_ONE;
            depth_next    = depth_reg + 1'b1;
          end else begin
            state_next = ST_SPILL;
          end
        end else if (ret_i && !call_i) begin
          if (depth_reg == '0) begin
            unf_next = 1'b1;
          end else if (resident_reg > RES_ONE) begin
            cwp_next      = cwp_reg - WIN_ONE;
            resident_next = resident_reg - RES_ONE;
            depth_next    = depth_reg - 1'b1;
          end else begin
            state_next = ST_FILL;
          end
        end
      end
      // Resident count is unchanged across a transfer: one window leaves as another enters.
      ST_SPILL: begin
        if (lsu.spill_ack_i) begin
          cwp_next   = cwp_reg + WIN_ONE;
          depth_next = depth_reg + 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (lsu.fill_ack_i) begin
          cwp_next   = cwp_reg - WIN_ONE;
          depth_next = depth_reg - 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o          = 1'b0;
    lsu.spill_req_o = 1'b0;
    lsu.spill_win_o = '0;
    lsu.fill_req_o  = 1'b0;
    lsu.fill_win_o  = '0;
    case (state_reg)
      ST_SPILL: begin
        busy_o          = 1'b1;
        lsu.spill_req_o = 1'b1;
        lsu.spill_win_o = cwp_reg + WIN_ONE;
      end
      ST_FILL: begin
        busy_o         = 1'b1;
        lsu.fill_req_o = 1'b1;
        lsu.fill_win_o = cwp_reg - WIN_ONE;
      end
      default: ;
    endcase
  end

  assign dec_valid_o = dec_valid_reg;
  assign rd_addr_o   = rd_addr_reg;
  assign rp_addr_o   = rp_addr_reg;
  assign depth_o     = depth_reg;
  assign underflow_o = unf_reg;
  assign overflow_o  = ovf_reg;

endmodule

// File: tb/tb_reg_window_decoder.sv
// Randomized bench for reg_window_decoder against a window/depth model (NWIN=4, FW=2, PAW=6).
module tb_reg_window_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid_i;
  logic [3:0] r_i;
  logic       dec_valid_o;
  logic [5:0] rd_addr_o, rp_addr_o;
  logic       call_i, ret_i, busy_o;
  logic [7:0] depth_o;
  logic       underflow_o, overflow_o;

  reg_window_decoder_if #(.WPW(2)) lsu_if ();

  reg_window_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid_i (dec_valid_i),
    .r_i         (r_i),
    .dec_valid_o (dec_valid_o),
    .rd_addr_o   (rd_addr_o),
    .rp_addr_o   (rp_addr_o),
    .call_i      (call_i),
    .ret_i       (ret_i),
    .busy_o      (busy_o),
    .lsu         (lsu_if.master),
    .depth_o     (depth_o),
    .underflow_o (underflow_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nstep  = 0;

  // Reference model: window pointer, call depth and resident count as plain integers.
  int m_cwp, m_depth, m_res;
  bit m_spilling, m_filling, m_ovf, m_unf;
  int exp_rd, exp_rp;
  bit exp_dv;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cwp = 0; m_depth = 0; m_res = 1;
    m_spilling = 0; m_filling = 0; m_ovf = 0; m_unf = 0;
    exp_rd = 0; exp_rp = 0; exp_dv = 0;
  endtask

  task automatic check_outputs(input string ph);
    check_val({ph, "_dv"},    32'(dec_valid_o), 32'(exp_dv));
    check_val({ph, "_rd"},    32'(rd_addr_o),   32'(exp_rd));
    check_val({ph, "_rp"},    32'(rp_addr_o),   32'(exp_rp));
    check_val({ph, "_busy"},  32'(busy_o),      32'(m_spilling | m_filling));
    check_val({ph, "_sreq"},  32'(lsu_if.spill_req_o), 32'(m_spilling));
    check_val({ph, "_swin"},  32'(lsu_if.spill_win_o), m_spilling ? 32'((m_cwp + 1) % 4) : 32'd0);
    check_val({ph, "_freq"},  32'(lsu_if.fill_req_o),  32'(m_filling));
    check_val({ph, "_fwin"},  32'(lsu_if.fill_win_o),  m_filling ? 32'((m_cwp + 3) % 4) : 32'd0);
    check_val({ph, "_depth"}, 32'(depth_o),     32'(m_depth));
    check_val({ph, "_unf"},   32'(underflow_o), 32'(m_unf));
    check_val({ph, "_ovf"},   32'(overflow_o),  32'(m_ovf));
  endtask

  task automatic model_update(input bit c, input bit rt, input bit sa, input bit fa);
    if (m_spilling) begin
      if (sa) begin m_cwp = (m_cwp + 1) % 4; m_depth++; m_spilling = 0; end
    end else if (m_filling) begin
      if (fa) begin m_cwp = (m_cwp + 3) % 4; m_depth--; m_filling = 0; end
    end else if (c && !rt) begin
      if (m_depth == 255) m_ovf = 1;
      else if (m_res < 4) begin m_cwp = (m_cwp + 1) % 4; m_res++; m_depth++; end
      else m_spilling = 1;
    end else if (rt && !c) begin
      if (m_depth == 0) m_unf = 1;
      else if (m_res > 1) begin m_cwp = (m_cwp + 3) % 4; m_res--; m_depth--; end
      else m_filling = 1;
    end
  endtask

  task automatic step(input string ph, input bit dv, input logic [3:0] r,
                      input bit c, input bit rt, input bit sa, input bit fa);
    int caller;
    dec_valid_i = dv; r_i = r; call_i = c; ret_i = rt;
    lsu_if.spill_ack_i = sa; lsu_if.fill_ack_i = fa;
    @(posedge clk);
    caller = (m_depth > 0) ? (m_cwp + 3) % 4 : m_cwp;
    exp_rd = m_cwp * 16 + 3 * 4 + int'(r[3:2]);
    exp_rp = caller * 16 + 2 * 4 + int'(r[1:0]);
    exp_dv = dv;
    model_update(c, rt, sa, fa);
    #1;
    check_outputs(ph);
    nstep++;
    $display("txn %0d %s dv=%0d r=%b call=%0d ret=%0d sack=%0d fack=%0d -> rd=%b rp=%b depth=%0d busy=%0d",
             nstep, ph, dv, r, c, rt, sa, fa, rd_addr_o, rp_addr_o, depth_o, busy_o);
  endtask

  task automatic apply_reset(input string ph);
    rst_n = 1'b0;
    dec_valid_i = 0; r_i = '0; call_i = 0; ret_i = 0;
    lsu_if.spill_ack_i = 0; lsu_if.fill_ack_i = 0;
    model_reset();
    #1;
    check_outputs(ph);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    apply_reset("rst");

    // 1: decode right after reset
    step("t1", 1, 4'b1010, 0, 0, 0, 0);
    check_val("t1_rd_lit", 32'(rd_addr_o), 32'b001110);
    check_val("t1_rp_lit", 32'(rp_addr_o), 32'b001010);

    // 2: three calls, decode in window 3, then simultaneous call+ret
    for (int i = 0; i < 3; i++) step("t2_call", 0, 4'b0000, 1, 0, 0, 0);
    step("t2_dec", 1, 4'b0111, 0, 0, 0, 0);
    check_val("t2_rd_lit", 32'(rd_addr_o), 32'b111101);
    check_val("t2_rp_lit", 32'(rp_addr_o), 32'b101011);
    step("t2_both", 0, 4'b0000, 1, 1, 0, 0);
    check_val("t2_both_depth", 32'(depth_o), 32'd3);

    // 3: fourth call spills the oldest window; stray call while busy is dropped
    step("t3_call", 0, 4'b0000, 1, 0, 0, 0);
    check_val("t3_sreq_lit", 32'(lsu_if.spill_req_o), 32'd1);
    check_val("t3_swin_lit", 32'(lsu_if.spill_win_o), 32'd0);
    step("t3_wait", 0, 4'b0000, 0, 0, 0, 0);
    step("t3_stray", 0, 4'b0000, 1, 0, 0, 1);
    step("t3_wait", 0, 4'b0000, 0, 0, 0, 0);
    step("t3_ack", 1, 4'b0000, 0, 0, 1, 0);
    step("t3_dec", 1, 4'b0000, 0, 0, 0, 0);
    check_val("t3_depth_lit", 32'(depth_o), 32'd4);
    check_val("t3_cwp_lit", 32'(rd_addr_o[5:4]), 32'd0);

    // 4: four returns; the last needs a fill
    for (int i = 0; i < 4; i++) step("t4_ret", 1, 4'b0000, 0, 1, 0, 0);
    check_val("t4_freq_lit", 32'(lsu_if.fill_req_o), 32'd1);
    check_val("t4_fwin_lit", 32'(lsu_if.fill_win_o), 32'd0);
    step("t4_ack", 1, 4'b0000, 0, 0, 0, 1);
    step("t4_dec", 1, 4'b0000, 0, 0, 0, 0);
    check_val("t4_depth_lit", 32'(depth_o), 32'd0);

    // 5: underflow is sticky
    step("t5_ret", 1, 4'b0101, 0, 1, 0, 0);
    check_val("t5_unf_lit", 32'(underflow_o), 32'd1);
    step("t5_call", 1, 4'b0101, 1, 0, 0, 0);
    check_val("t5_unf_sticky", 32'(underflow_o), 32'd1);

    // Randomized traffic, including acks outside their matching state
    for (int i = 0; i < 1200; i++) begin
      int op;
      bit c, rt;
      op = $urandom_range(0, 9);
      c  = (op <= 3) || (op == 8);
      rt = (op >= 4 && op <= 8);
      step("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), c, rt,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    // 6: reset in the middle of a spill
    apply_reset("t6_pre");
    for (int i = 0; i < 4; i++) step("t6_call", 0, 4'b0000, 1, 0, 0, 0);
    check_val("t6_sreq_pre", 32'(lsu_if.spill_req_o), 32'd1);
    #3;
    apply_reset("t6_rst");
    step("t6_dec", 1, 4'b1010, 0, 0, 0, 0);
    check_val("t6_rd_lit", 32'(rd_addr_o), 32'b001110);

    // Drive depth to its maximum, then one more call overflows
    guard = 0;
    while (m_depth < 255 && guard < 3000) begin
      if (m_spilling) step("ovf_ack", 0, 4'b0000, 0, 0, 1, 0);
      else            step("ovf_call", 0, 4'b0000, 1, 0, 0, 0);
      guard++;
    end
    check_val("ovf_depth_max", 32'(depth_o), 32'd255);
    step("ovf_call", 1, 4'b0000, 1, 0, 0, 0);
    check_val("ovf_flag_lit", 32'(overflow_o), 32'd1);
    check_val("ovf_depth_hold", 32'(depth_o), 32'd255);
    step("ovf_ret", 1, 4'b0000, 0, 1, 0, 0);
    check_val("ovf_sticky", 32'(overflow_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
